// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ writeback
// sources, with a registered write stage and a pending-write scoreboard for RAW detection.
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      claim_valid,
  input  logic [ADDR_W-1:0]         claim_reg,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         rs,
  input  logic [ADDR_W-1:0]         rt,
  output logic                      hazard_rs,
  output logic                      hazard_rt,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic [NUM_REGS-1:0]       pending,
  output logic                      range_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0]  grant;
  logic                accept;
  logic                sel_ok;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] pend_nxt;

  // Search upward from rr_ptr with wrap; the grant depends only on valids and the
  // pointer, never on the data being offered.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    gnt_idx  = '0;
    sel_reg  = '0;
    sel_data = '0;
    accept   = 1'b0;
    if (reset && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!accept && req_valid[idx]) begin
          accept     = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = PTR_W'(idx);
          sel_reg    = req_reg[idx*ADDR_W +: ADDR_W];
          sel_data   = req_data[idx*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign req_ready = grant;
  assign sel_ok    = int'(sel_reg) < NUM_REGS;
  assign ptr_nxt   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  // Out-of-range destinations are consumed but never reach the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      range_err  <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      RegWrite <= accept && sel_ok;
      if (accept)
        rr_ptr <= ptr_nxt;
      if (accept && sel_ok) begin
        write_reg  <= sel_reg;
        write_data <= sel_data;
      end
      if (accept && !sel_ok)
        range_err <= 1'b1;
    end
  end

  // Claim is applied after the clear so a newer claim keeps ownership of the register.
  always_comb begin
    pend_nxt = pending;
    for (int r = 0; r < NUM_REGS; r++)
      if (RegWrite && write_reg == ADDR_W'(r))
        pend_nxt[r] = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      if (claim_valid && claim_reg == ADDR_W'(r))
        pend_nxt[r] = 1'b1;
    if (flush)
      pend_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pending <= '0;
    else
      pending <= pend_nxt;
  end

  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rs == ADDR_W'(r)) hazard_rs = pending[r];
      if (rt == ADDR_W'(r)) hazard_rt = pending[r];
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter plus hand sequences for
// async reset, reset release and flush.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [9:0]  req_reg;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        claim_valid;
  logic [4:0]  claim_reg;
  logic        flush;
  logic [4:0]  rs, rt;
  logic        hazard_rs, hazard_rt;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [7:0]  pending;
  logic        range_err;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_reg(req_reg),
    .req_data(req_data), .req_ready(req_ready), .claim_valid(claim_valid),
    .claim_reg(claim_reg), .flush(flush), .rs(rs), .rt(rt),
    .hazard_rs(hazard_rs), .hazard_rt(hazard_rt), .RegWrite(RegWrite),
    .write_reg(write_reg), .write_data(write_data), .pending(pending),
    .range_err(range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [4:0]  r0;
    logic [31:0] d0;
    logic [4:0]  r1;
    logic [31:0] d1;
    logic        cv;
    logic [4:0]  cr;
    logic        fl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [1:0]  rdy;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [7:0]  pend;
    logic        hs;
    logic        ht;
    logic        re;
  } vec_t;

  vec_t v [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // inputs: vld r0 d0 r1 d1 cv cr fl rs rt | expected: rdy we wr wd pend hs ht re
    v[0]  = '{2'b01, 3, 'hA5, 0, 0,     0, 0, 0, 0, 0, 2'b01, 0, 0, 'h00, 'h00, 0, 0, 0};
    v[1]  = '{2'b00, 0, 0,    0, 0,     0, 0, 0, 0, 0, 2'b00, 1, 3, 'hA5, 'h00, 0, 0, 0};
    v[2]  = '{2'b11, 1, 'h11, 2, 'h22,  0, 0, 0, 0, 0, 2'b10, 0, 3, 'hA5, 'h00, 0, 0, 0};
    v[3]  = '{2'b11, 1, 'h11, 2, 'h22,  0, 0, 0, 0, 0, 2'b01, 1, 2, 'h22, 'h00, 0, 0, 0};
    v[4]  = '{2'b11, 1, 'h11, 2, 'h22,  0, 0, 0, 0, 0, 2'b10, 1, 1, 'h11, 'h00, 0, 0, 0};
    v[5]  = '{2'b00, 0, 0,    0, 0,     1, 5, 0, 5, 2, 2'b00, 1, 2, 'h22, 'h00, 0, 0, 0};
    v[6]  = '{2'b00, 0, 0,    0, 0,     0, 0, 0, 5, 9, 2'b00, 0, 2, 'h22, 'h20, 1, 0, 0};
    v[7]  = '{2'b10, 0, 0,    5, 'h55,  0, 0, 0, 5, 9, 2'b10, 0, 2, 'h22, 'h20, 1, 0, 0};
    v[8]  = '{2'b00, 0, 0,    0, 0,     0, 0, 0, 5, 9, 2'b00, 1, 5, 'h55, 'h20, 1, 0, 0};
    v[9]  = '{2'b00, 0, 0,    0, 0,     1, 5, 0, 5, 9, 2'b00, 0, 5, 'h55, 'h00, 0, 0, 0};
    v[10] = '{2'b01, 5, 'h66, 0, 0,     0, 0, 0, 5, 9, 2'b01, 0, 5, 'h55, 'h20, 1, 0, 0};
    v[11] = '{2'b00, 0, 0,    0, 0,     1, 5, 0, 5, 9, 2'b00, 1, 5, 'h66, 'h20, 1, 0, 0};
    v[12] = '{2'b00, 0, 0,    0, 0,     1, 9, 0, 5, 9, 2'b00, 0, 5, 'h66, 'h20, 1, 0, 0};
    v[13] = '{2'b01, 12, 'h77, 0, 0,    0, 0, 0, 5, 9, 2'b01, 0, 5, 'h66, 'h20, 1, 0, 0};
    v[14] = '{2'b00, 0, 0,    0, 0,     0, 0, 0, 5, 9, 2'b00, 0, 5, 'h66, 'h20, 1, 0, 1};
    v[15] = '{2'b11, 1, 'h11, 2, 'h22,  1, 3, 1, 5, 3, 2'b00, 0, 5, 'h66, 'h20, 1, 0, 1};
    v[16] = '{2'b11, 1, 'h11, 2, 'h22,  0, 0, 0, 5, 3, 2'b10, 0, 5, 'h66, 'h00, 0, 0, 1};
    v[17] = '{2'b01, 1, 'h11, 0, 0,     0, 0, 1, 5, 3, 2'b00, 1, 2, 'h22, 'h00, 0, 0, 1};
    v[18] = '{2'b00, 0, 0,    0, 0,     0, 0, 0, 5, 3, 2'b00, 0, 2, 'h22, 'h00, 0, 0, 1};

    reset = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
    claim_valid = 1'b0; claim_reg = '0; flush = 1'b0; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_regwrite", 32'(RegWrite), 0);
    chk("rst_write_reg", 32'(write_reg), 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_range_err", 32'(range_err), 0);
    req_valid = '0;
    #1;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) begin
      req_valid   = v[i].vld;
      req_reg     = {v[i].r1, v[i].r0};
      req_data    = {v[i].d1, v[i].d0};
      claim_valid = v[i].cv;
      claim_reg   = v[i].cr;
      flush       = v[i].fl;
      rs          = v[i].rs;
      rt          = v[i].rt;
      #1;
      chk($sformatf("v%0d_ready", i),      32'(req_ready),  32'(v[i].rdy));
      chk($sformatf("v%0d_regwrite", i),   32'(RegWrite),   32'(v[i].we));
      chk($sformatf("v%0d_write_reg", i),  32'(write_reg),  32'(v[i].wr));
      chk($sformatf("v%0d_write_data", i), write_data,      v[i].wd);
      chk($sformatf("v%0d_pending", i),    32'(pending),    32'(v[i].pend));
      chk($sformatf("v%0d_hazard_rs", i),  32'(hazard_rs),  32'(v[i].hs));
      chk($sformatf("v%0d_hazard_rt", i),  32'(hazard_rt),  32'(v[i].ht));
      chk($sformatf("v%0d_range_err", i),  32'(range_err),  32'(v[i].re));
      tick();
    end

    // Fill the scoreboard, then launch a write so RegWrite is high when reset hits.
    req_valid = '0; flush = 1'b0;
    for (int r = 0; r < 8; r++) begin
      claim_valid = 1'b1;
      claim_reg   = 5'(r);
      tick();
    end
    claim_valid = 1'b0;
    req_valid = 2'b01; req_reg = {5'd0, 5'd1}; req_data = {32'h0, 32'hDEAD};
    #1;
    chk("seq_ready_before_rst", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    chk("seq_regwrite_before_rst", 32'(RegWrite), 1);
    chk("seq_pending_before_rst", 32'(pending), 32'hFF);
    #2;
    reset = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("async_regwrite", 32'(RegWrite), 0);
    chk("async_write_reg", 32'(write_reg), 0);
    chk("async_write_data", write_data, 0);
    chk("async_pending", 32'(pending), 0);
    chk("async_range_err", 32'(range_err), 0);
    chk("async_ready", 32'(req_ready), 0);
    req_valid = '0;
    #2;
    reset = 1'b1;
    tick();
    chk("post_rst_regwrite_a", 32'(RegWrite), 0);
    tick();
    chk("post_rst_regwrite_b", 32'(RegWrite), 0);
    req_valid = 2'b11;
    #1;
    chk("post_rst_rr_ptr", 32'(req_ready), 32'b01);
    req_valid = '0;
    claim_valid = 1'b1; claim_reg = 5'd2;
    tick();
    claim_valid = 1'b0;
    chk("flush_pre_pending", 32'(pending), 32'h04);
    rs = 5'd2;
    #1;
    chk("flush_pre_hazard", 32'(hazard_rs), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_pending", 32'(pending), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
